// File: rtl/spi_slave_port_if.sv
// ---------------------------------------------------------------------------
// spi_slave_port_if
//   Bundles the serial pins and the local-side RX/TX handshakes of the SPI
//   peripheral endpoint.
//
//   Serial side : sck, ss_n, mosi (in to slave), miso, miso_oe (out of slave)
//   TX side     : tx_data, tx_write (in), tx_empty (out)
//   RX side     : rx_read (in), rx_data, rx_valid, overrun (out)
//   Status      : busy, fsm_state (out, fsm_state = 0 IDLE / 1 SHIFT)
//
//   Handshake semantics (strobes, not valid/ready pairs):
//     tx_write is a one-cycle strobe, accepted only while tx_empty=1;
//     rx_read is a one-cycle strobe, effective only while rx_valid=1;
//     rx_valid stays high until consumed.
// ---------------------------------------------------------------------------
interface spi_slave_port_if #(
  parameter int WIDTH = 8
);
  logic             sck;
  logic             ss_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_write;
  logic             tx_empty;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_read;
  logic             overrun;
  logic             busy;
  logic             fsm_state;

  modport slave (
    input  sck, ss_n, mosi, tx_data, tx_write, rx_read,
    output miso, miso_oe, tx_empty, rx_data, rx_valid, overrun, busy, fsm_state
  );

  modport master (
    output sck, ss_n, mosi, tx_data, tx_write, rx_read,
    input  miso, miso_oe, tx_empty, rx_data, rx_valid, overrun, busy, fsm_state
  );
endinterface

// File: rtl/spi_slave_port.sv
// ---------------------------------------------------------------------------
// spi_slave_port
//   SPI peripheral endpoint, CPOL=0 / CPHA=0, LSB-first frames of WIDTH bits.
//   SCK, SS_N and MOSI are oversampled on the local clock through
//   SYNC_STAGES-deep synchronizers. A received frame is buffered in rx_data
//   with an rx_valid/rx_read handshake; the byte returned on MISO comes from
//   a single-entry TX holding register filled with tx_write.
//
//   Ports:
//     clk  - system clock, all state on rising edge
//     clr  - asynchronous active-high reset
//     bus  - spi_slave_port_if.slave (serial pins, RX/TX handshakes, status)
// ---------------------------------------------------------------------------
module spi_slave_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                clr,
  spi_slave_port_if.slave     bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Input synchronizers. SS_N resets to 1 so reset never looks like a select.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  // Datapath state
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] tx_hold_q;
  logic             tx_empty_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             overrun_q;

  // FSM control strobes
  logic start, bit_inc, complete, shift_tx, load;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] next_tx;

  assign rx_word = {mosi_s, rx_shift_q[WIDTH-1:1]};
  assign next_tx = tx_empty_q ? '0 : tx_hold_q;
  // The holding register is consumed both on select and on every completion,
  // so back-to-back frames under a continuous select each get a fresh byte.
  assign load    = start | complete;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    bit_inc  = 1'b0;
    complete = 1'b0;
    shift_tx = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_s) begin
          // Deselect at any count abandons the partial frame.
          state_d = IDLE;
        end else if (sck_rise) begin
          if (count_q == LAST) complete = 1'b1;
          else                 bit_inc  = 1'b1;
        end else if (sck_fall && count_q != '0) begin
          // The falling edge right after completion (count 0) must not shift:
          // the reloaded bit 0 is already on MISO for the next frame.
          shift_tx = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers and bit counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q    <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
    end else begin
      if (start || complete) begin
        count_q    <= '0;
        rx_shift_q <= '0;
      end else if (bit_inc) begin
        count_q    <= count_q + CW'(1);
        rx_shift_q <= rx_word;
      end
      if (load)          tx_shift_q <= next_tx;
      else if (shift_tx) tx_shift_q <= {1'b0, tx_shift_q[WIDTH-1:1]};
    end
  end

  // TX holding register. A write coinciding with a load is kept for the
  // following frame; the load itself sees the prior content.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tx_hold_q  <= '0;
      tx_empty_q <= 1'b1;
    end else if (load) begin
      if (bus.tx_write) begin
        tx_hold_q  <= bus.tx_data;
        tx_empty_q <= 1'b0;
      end else begin
        tx_hold_q  <= '0;
        tx_empty_q <= 1'b1;
      end
    end else if (bus.tx_write && tx_empty_q) begin
      tx_hold_q  <= bus.tx_data;
      tx_empty_q <= 1'b0;
    end
  end

  // RX buffer. A read in the completion cycle frees the slot for the new word.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (complete) begin
      if (!rx_valid_q || bus.rx_read) begin
        rx_data_q  <= rx_word;
        rx_valid_q <= 1'b1;
      end else begin
        overrun_q  <= 1'b1;
      end
    end else if (bus.rx_read) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.miso      = (state_q == SHIFT) & tx_shift_q[0];
  assign bus.miso_oe   = (state_q == SHIFT);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.fsm_state = state_q;
  assign bus.tx_empty  = tx_empty_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI peripheral-side endpoint. It is the far end of the link driven by the team's shift-register sender/receiver pair.
- Samples SCK/SS_N/MOSI on the local system clock, shifts in 8-bit frames LSB-first, and returns a pre-loaded TX byte on MISO.
- Exposes a buffered RX byte with a valid/read handshake and a single-entry TX holding register to the local logic.
- Protocol mode: CPOL=0, CPHA=0.

Parameters:
- WIDTH, 8, frame length in bits.
- SYNC_STAGES, 2, flip-flop stages in each of the SCK, SS_N and MOSI input synchronizers (minimum 2).

Ports:
- CLK  input  1  system clock; all state on its rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- SCK  input  1  serial clock from master; asynchronous to CLK.
- SS_N  input  1  slave select, active-low, asynchronous.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master; driven 0 when MISO_OE=0.
- MISO_OE  output  1  high while selected (state SHIFT).
- TX_DATA  input  WIDTH  byte to return on the next frame.
- TX_WRITE  input  1  one-cycle strobe; loads TX_DATA into the holding register.
- TX_EMPTY  output  1  holding register free.
- RX_DATA  output  WIDTH  last completed received frame.
- RX_VALID  output  1  RX_DATA unread.
- RX_READ  input  1  one-cycle strobe; consumes RX_DATA.
- OVERRUN  output  1  sticky; a frame completed while RX_VALID=1 and no RX_READ.
- BUSY  output  1  high in state SHIFT.

Behaviour:
- Reset (CLR=1, asynchronous):
  - State IDLE, bit count 0, shift registers 0.
  - Synchronizer flops: SCK stages 0, SS_N stages 1.
  - MISO=0, MISO_OE=0, BUSY=0, TX_EMPTY=1, RX_DATA=0, RX_VALID=0, OVERRUN=0.
  - The TX holding register is cleared.
- Input conditioning:
  - SCK, SS_N and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronized SCK samples.
  - SCK high and low phases must each be at least 4 CLK periods. Faster SCK is out of spec.
- State machine, two states:
  - IDLE -> SHIFT on synchronized SS_N = 0.
    - Same cycle: tx_shift <= holding register if TX_EMPTY=0, otherwise all zeros.
    - Holding register marked empty.
    - Bit count <= 0.
    - MISO = tx_shift[0], valid from the first cycle of SHIFT.
  - SHIFT, synchronized SCK rising edge:
    - rx_shift <= {MOSI_sync, rx_shift[WIDTH-1:1]}, i.e. LSB-first; first received bit lands in bit 0 at completion.
    - Bit count increments.
  - SHIFT, synchronized SCK falling edge with 1 <= count <= WIDTH-1: tx_shift shifts right by one and MISO follows tx_shift[0].
  - Frame completion, on the rising edge where count reaches WIDTH:
    - The completed word goes to RX_DATA and RX_VALID is set on the next CLK edge.
    - Count <= 0.
    - tx_shift is reloaded from the holding register, or zeros if empty, for back-to-back frames without leaving SHIFT.
  - SHIFT -> IDLE on synchronized SS_N = 1, at any count:
    - A partial frame is discarded: no RX_VALID, RX_DATA unchanged.
    - MISO_OE=0 and MISO=0 on the next cycle.
- Latency: RX_VALID rises at most SYNC_STAGES+2 CLK cycles after the raw 8th SCK rising edge.
- RX handshake:
  - RX_READ with RX_VALID=1 clears RX_VALID next cycle; RX_DATA holds its value.
  - RX_READ with RX_VALID=0 is ignored.
  - Completion and RX_READ in the same cycle: RX_DATA takes the new word, RX_VALID stays 1, no overrun.
  - Completion with RX_VALID=1 and no RX_READ: the new word is dropped, old RX_DATA kept, OVERRUN <= 1.
  - OVERRUN clears only on CLR.
- TX handshake:
  - TX_WRITE with TX_EMPTY=1 captures TX_DATA and sets TX_EMPTY=0 next cycle.
  - TX_WRITE with TX_EMPTY=0 is ignored; the holding register is not overwritten.
  - TX_WRITE in the same cycle as a load: the load uses the prior holding content (zeros if empty), and the new TX_DATA is retained for the following frame.
- Width rules:
  - The bit counter is clog2(WIDTH)+1 bits and never exceeds WIDTH.
  - Counts wrap to 0 only at completion or on abort.

Test Plan:
- Reset mid-frame: assert CLR after 3 SCK pulses -> all outputs at reset values immediately, without waiting for a CLK edge; the next full frame is received correctly.
- TX_WRITE 8'hA5, then SS_N low with 8 SCK pulses and MOSI driving 8'h3C LSB-first -> MISO sampled on SCK rises gives 1,0,1,0,0,1,0,1; RX_DATA=8'h3C; RX_VALID=1; TX_EMPTY=1.
- Two back-to-back frames with SS_N held low: MOSI 8'h01 then 8'h80, RX_READ pulsed between them, TX preloaded 8'hFF then 8'h00 written during frame 1 -> MISO returns 8'hFF then 8'h00; RX sequence 8'h01, 8'h80; OVERRUN=0.
- Overrun: two frames (8'h11, 8'h22) with no RX_READ -> RX_DATA=8'h11, OVERRUN=1 sticky. A later RX_READ clears RX_VALID only.
- Abort: SS_N high after 5 SCK pulses -> RX_VALID stays 0, BUSY=0, MISO_OE=0. The next frame with 8'h5A yields RX_DATA=8'h5A.
- Empty TX and ignored write: frame with TX_EMPTY=1 -> MISO all zeros. A TX_WRITE of 8'h12 followed by TX_WRITE 8'h34 while full -> the next frame returns 8'h12.
